io_request_arbiter: RTL and testbench

IO_REQUEST_ARBITER -- requirements
Module: io_request_arbiter

---
 rtl/io_request_arbiter_pkg.sv | 37 +++
 rtl/io_bus_interface.sv | 12 +
 rtl/rr_arbiter.sv | 48 ++++
 rtl/io_request_arbiter.sv | 101 ++++++++++
 tb/tb_io_request_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_request_arbiter_pkg.sv
// Shared types for the non-cached I/O request path: request/response packets,
// core identifiers and the arbiter FSM state encoding.
package io_request_arbiter_pkg;

  localparam int NUM_CORES        = 4;
  localparam int THREADS_PER_CORE = 4;
  localparam int CORE_ID_WIDTH    = 4;

  typedef logic [CORE_ID_WIDTH-1:0]            core_id_t;
  typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;

  typedef struct packed {
    logic              is_store;
    local_thread_idx_t thread_idx;
    logic [31:0]       address;
    logic [31:0]       value;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    logic [31:0]       read_value;
  } iorsp_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    RESPOND
  } io_arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_bus_interface.sv
// Shared non-cached peripheral bus: one-cycle read/write strobes, read data
// returned by the slave in the following cycle.
interface io_bus_interface;
  logic        write_en;
  logic        read_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master(output write_en, read_en, address, write_data, input read_data);
  modport slave(input write_en, read_en, address, write_data, output read_data);
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the requester after the most recent winner has highest
// priority, ascending with wrap-around. The winner is remembered on update_lru.
module rr_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W:0]   candidate;
  logic             found;

  always_comb begin
    grant_oh  = '0;
    grant_idx = last_grant_reg;
    candidate = '0;
    found     = 1'b0;
    for (int i = 1; i <= NUM_REQUESTERS; i++) begin
      candidate = {1'b0, last_grant_reg} + (IDX_W+1)'(i);
      if (candidate >= (IDX_W+1)'(NUM_REQUESTERS))
        candidate = candidate - (IDX_W+1)'(NUM_REQUESTERS);
      if (!found && request[candidate[IDX_W-1:0]]) begin
        found     = 1'b1;
        grant_idx = candidate[IDX_W-1:0];
      end
    end
    if (found)
      grant_oh[grant_idx] = 1'b1;
  end

  // Reset to the last index so requester 0 is first in line.
  always_ff @(posedge clk) begin
    if (reset)
      last_grant_reg <= IDX_W'(NUM_REQUESTERS - 1);
    else if (update_lru && found)
      last_grant_reg <= grant_idx;
  end

endmodule

// File: rtl/io_request_arbiter.sv
// Serialises per-core non-cached I/O requests onto one peripheral bus and
// broadcasts each response back: grant, bus strobe, capture, respond.
module io_request_arbiter
  import io_request_arbiter_pkg::*;
#(
  parameter int NUM_REQUESTERS = NUM_CORES
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQUESTERS-1:0]          ioreq_valid,
  input  ioreq_packet_t [NUM_REQUESTERS-1:0] ioreq_packet,
  output logic [NUM_REQUESTERS-1:0]          ioreq_ack,
  io_bus_interface.master                    io_bus,
  output logic                               iorsp_valid,
  output iorsp_packet_t                      iorsp_packet
);

  localparam int IDX_W = idx_width(NUM_REQUESTERS);

  io_arb_state_t             state_reg;
  ioreq_packet_t             req_reg;
  logic [IDX_W-1:0]          grant_idx_reg;
  logic                      write_en_reg;
  logic                      read_en_reg;
  logic                      rsp_valid_reg;
  iorsp_packet_t             rsp_reg;
  logic [NUM_REQUESTERS-1:0] grant_oh;
  logic [IDX_W-1:0]          grant_idx;
  logic [IDX_W-1:0]          idx_terms [NUM_REQUESTERS];
  logic                      arb_enable;

  // Arbitration is only live in IDLE; the ack is the grant itself that cycle.
  assign arb_enable = (state_reg == IDLE) && !reset;
  assign ioreq_ack  = arb_enable ? grant_oh : '0;

  rr_arbiter #(
    .NUM_REQUESTERS(NUM_REQUESTERS)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .request   (ioreq_valid),
    .update_lru(arb_enable),
    .grant_oh  (grant_oh)
  );

  for (genvar gi = 0; gi < NUM_REQUESTERS; gi++) begin : g_encode
    assign idx_terms[gi] = grant_oh[gi] ? IDX_W'(gi) : '0;
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++)
      grant_idx = grant_idx | idx_terms[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      req_reg       <= '0;
      grant_idx_reg <= '0;
      write_en_reg  <= 1'b0;
      read_en_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_reg       <= '0;
    end else begin
      write_en_reg  <= 1'b0;
      read_en_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|grant_oh) begin
            req_reg       <= ioreq_packet[grant_idx];
            grant_idx_reg <= grant_idx;
            write_en_reg  <= ioreq_packet[grant_idx].is_store;
            read_en_reg   <= !ioreq_packet[grant_idx].is_store;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: state_reg <= CAPTURE;
        CAPTURE: begin
          // Stores report zero so every response carries a defined value.
          rsp_reg.core       <= core_id_t'(grant_idx_reg);
          rsp_reg.thread_idx <= req_reg.thread_idx;
          rsp_reg.read_value <= req_reg.is_store ? 32'h0 : io_bus.read_data;
          rsp_valid_reg      <= 1'b1;
          state_reg          <= RESPOND;
        end
        RESPOND: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign io_bus.write_en   = write_en_reg;
  assign io_bus.read_en    = read_en_reg;
  assign io_bus.address    = req_reg.address;
  assign io_bus.write_data = req_reg.value;
  assign iorsp_valid       = rsp_valid_reg;
  assign iorsp_packet      = rsp_reg;

endmodule

// File: tb/tb_io_request_arbiter.sv
// Randomised bench for io_request_arbiter: a request-level reference model
// predicts grants, bus operations and responses into scoreboard queues.
module tb_io_request_arbiter;
  import io_request_arbiter_pkg::*;

  localparam int N      = 4;
  localparam int M_IDLE = 0;
  localparam int M_HOLD = 1;
  localparam int M_RAND = 2;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N-1:0]          ioreq_valid;
  ioreq_packet_t [N-1:0] ioreq_packet;
  logic [N-1:0]          ioreq_ack;
  logic                  iorsp_valid;
  iorsp_packet_t         iorsp_packet;

  io_bus_interface io_bus();

  io_request_arbiter #(.NUM_REQUESTERS(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .ioreq_valid (ioreq_valid),
    .ioreq_packet(ioreq_packet),
    .ioreq_ack   (ioreq_ack),
    .io_bus      (io_bus),
    .iorsp_valid (iorsp_valid),
    .iorsp_packet(iorsp_packet)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_store;
    logic [1:0]  thread;
    logic [31:0] addr;
    logic [31:0] data;
    int          idx;
    int          cyc;
  } bus_exp_t;

  typedef struct {
    int          core;
    logic [1:0]  thread;
    logic [31:0] value;
    int          cyc;
  } rsp_exp_t;

  int       checks = 0;
  int       errors = 0;
  int       mode = M_IDLE;
  logic [N-1:0] hold_mask = '0;
  logic [N-1:0] ack_snap;
  bus_exp_t bus_q[$];
  rsp_exp_t rsp_q[$];
  int       grant_log[$];
  int       grant_cyc_log[$];
  int       cycle = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Peripheral contents as seen by the bench's bus slave.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'hffff0004) return 32'h12345678;
    return {a[15:0], ~a[15:0]} ^ 32'h0f1e2d3c;
  endfunction

  function automatic ioreq_packet_t rand_pkt();
    ioreq_packet_t p;
    p.is_store   = 1'($urandom_range(0, 1));
    p.thread_idx = 2'($urandom_range(0, 3));
    p.address    = {16'hffff, 14'($urandom_range(0, 16383)), 2'b00};
    p.value      = $urandom();
    return p;
  endfunction

  // Reference model and scoreboard: the bus is busy for four cycles after a
  // grant; when free, the first valid requester after the last winner wins.
  initial begin
    int       model_last;
    int       last_grant_cyc;
    int       winner;
    bus_exp_t b;
    rsp_exp_t r;
    model_last       = N - 1;
    last_grant_cyc   = -100;
    io_bus.read_data = '0;
    forever begin
      @(negedge clk);
      cycle++;
      if (reset) begin
        check("reset_strobes", 32'({ioreq_ack, io_bus.write_en, io_bus.read_en, iorsp_valid}), 32'h0);
        bus_q.delete();
        rsp_q.delete();
        model_last     = N - 1;
        last_grant_cyc = -100;
        continue;
      end
      winner = -1;
      if (cycle - last_grant_cyc >= 4) begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (model_last + k) % N;
          if (winner < 0 && ioreq_valid[c]) winner = c;
        end
      end
      if (winner >= 0) begin
        check("grant_ack", 32'(ioreq_ack), 32'(1) << winner);
        b.is_store = ioreq_packet[winner].is_store;
        b.thread   = ioreq_packet[winner].thread_idx;
        b.addr     = ioreq_packet[winner].address;
        b.data     = ioreq_packet[winner].value;
        b.idx      = winner;
        b.cyc      = cycle + 1;
        bus_q.push_back(b);
        grant_log.push_back(winner);
        grant_cyc_log.push_back(cycle);
        model_last     = winner;
        last_grant_cyc = cycle;
      end else begin
        check("no_ack", 32'(ioreq_ack), 32'h0);
      end
      if (io_bus.write_en || io_bus.read_en) begin
        check("single_strobe", 32'(io_bus.write_en & io_bus.read_en), 32'h0);
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus: we=%b re=%b addr=%h, required no bus strobe", io_bus.write_en, io_bus.read_en, io_bus.address);
        end else begin
          b = bus_q.pop_front();
          check("bus_cycle", 32'(cycle), 32'(b.cyc));
          check("bus_write_en", 32'(io_bus.write_en), 32'(b.is_store));
          check("bus_address", io_bus.address, b.addr);
          if (b.is_store) check("bus_write_data", io_bus.write_data, b.data);
          io_bus.read_data = b.is_store ? $urandom() : slave_data(io_bus.address);
          r.core   = b.idx;
          r.thread = b.thread;
          r.value  = b.is_store ? 32'h0 : slave_data(b.addr);
          r.cyc    = cycle + 2;
          rsp_q.push_back(r);
        end
      end
      if (iorsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: core=%0d value=%h, required no response", iorsp_packet.core, iorsp_packet.read_value);
        end else begin
          r = rsp_q.pop_front();
          check("rsp_cycle", 32'(cycle), 32'(r.cyc));
          check("rsp_core", 32'(iorsp_packet.core), 32'(r.core));
          check("rsp_thread", 32'(iorsp_packet.thread_idx), 32'(r.thread));
          check("rsp_value", iorsp_packet.read_value, r.value);
          $display("rsp cycle=%0d core=%0d thread=%0d value=%h", cycle, iorsp_packet.core, iorsp_packet.thread_idx, iorsp_packet.read_value);
        end
      end
    end
  end

  // One cycle of stimulus: acked requests drop (or are renewed in hold mode)
  // with a scrambled packet so late input changes are exercised.
  task automatic step();
    @(negedge clk);
    ack_snap = ioreq_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ack_snap[i]) begin
        ioreq_packet[i] = rand_pkt();
        ioreq_valid[i]  = (mode == M_HOLD) && hold_mask[i];
      end else if (!ioreq_valid[i] && ((mode == M_HOLD && hold_mask[i]) ||
                                       (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
        ioreq_packet[i] = rand_pkt();
        ioreq_valid[i]  = 1'b1;
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (ioreq_valid != '0 && n < 80) begin
      step();
      n++;
    end
    if (ioreq_valid != '0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: valid=%b still pending, required all granted", name, ioreq_valid);
    end
    repeat (5) step();
  endtask

  task automatic check_log(input string name, input int pos, input int exp_idx);
    if (grant_log.size() <= pos) begin
      checks++;
      errors++;
      $display("FAIL %s: only %0d grants logged, expected requester %0d", name, grant_log.size(), exp_idx);
    end else begin
      check(name, 32'(grant_log[pos]), 32'(exp_idx));
    end
  endtask

  initial begin
    int gl;
    int n;
    int fair_exp[5] = '{0, 1, 2, 3, 0};
    ioreq_valid  = '0;
    ioreq_packet = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_address", io_bus.address, 32'h0);
    check("rst_write_data", io_bus.write_data, 32'h0);
    check("rst_rsp_value", iorsp_packet.read_value, 32'h0);
    check("rst_rsp_core", 32'(iorsp_packet.core), 32'h0);

    // Single load, then a store from requester 2.
    step();
    ioreq_packet[0] = '{is_store: 1'b0, thread_idx: 2'd1, address: 32'hffff0004, value: 32'h0};
    ioreq_valid[0]  = 1'b1;
    drain("load");
    ioreq_packet[2] = '{is_store: 1'b1, thread_idx: 2'd3, address: 32'hffff0010, value: 32'hdeadbeef};
    ioreq_valid[2]  = 1'b1;
    drain("store");

    // Fairness from reset with all four holding requests.
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    gl = grant_log.size();
    mode = M_HOLD;
    hold_mask = '1;
    repeat (18) step();
    mode = M_IDLE;
    drain("fair");
    for (int k = 0; k < 5; k++) check_log("fair_order", gl + k, fair_exp[k]);
    for (int k = 1; k < 5; k++)
      if (grant_cyc_log.size() > gl + k)
        check("fair_spacing", 32'(grant_cyc_log[gl+k] - grant_cyc_log[gl+k-1]), 32'd4);

    // Wrap-around: after a grant to 3, requester 1 beats 3.
    ioreq_packet[3] = rand_pkt();
    ioreq_valid[3]  = 1'b1;
    drain("wrap_setup");
    gl = grant_log.size();
    ioreq_packet[1] = rand_pkt();
    ioreq_packet[3] = rand_pkt();
    ioreq_valid[1]  = 1'b1;
    ioreq_valid[3]  = 1'b1;
    drain("wrap");
    check_log("wrap_first", gl, 1);
    check_log("wrap_second", gl + 1, 3);

    // Reset during CAPTURE abandons the load; requester 0 then wins first.
    gl = grant_log.size();
    ioreq_packet[2] = '{is_store: 1'b0, thread_idx: 2'd2, address: 32'hffff0020, value: 32'h0};
    ioreq_valid[2]  = 1'b1;
    n = 0;
    ack_snap = '0;
    while (!ack_snap[2] && n < 20) begin
      step();
      n++;
    end
    if (!ack_snap[2]) begin
      checks++;
      errors++;
      $display("FAIL capture_reset_timeout: no ack for requester 2 within %0d cycles", n);
    end
    step();
    reset = 1'b1;
    ioreq_packet[0] = rand_pkt();
    ioreq_packet[3] = rand_pkt();
    ioreq_valid[0]  = 1'b1;
    ioreq_valid[3]  = 1'b1;
    step();
    step();
    reset = 1'b0;
    drain("capture_reset");
    check_log("capture_reset_pre", gl, 2);
    check_log("capture_reset_first", gl + 1, 0);
    check_log("capture_reset_second", gl + 2, 3);

    // Randomised traffic.
    mode = M_RAND;
    repeat (400) step();
    mode = M_IDLE;
    drain("random");
    check("bus_q_empty", 32'(bus_q.size()), 32'h0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
